// File: rtl/matcher_pkg.sv
// word_matcher shared types and constants.
// FSM states, pattern width, delimiter and end-of-text codes.
package matcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WORD,
    ST_SKIP
  } state_e;

  localparam int         MAX_LEN = 8;
  localparam logic [7:0] DELIM   = 8'h20;
  localparam logic [7:0] CMD_END = 8'h01;

endpackage

// File: rtl/word_matcher_if.sv
// Character-in / result-out stream bundle for word_matcher.
// s_axis_*: char beats (no tready); m_axis_*: 1-cycle result pulses.
interface word_matcher_if;

  logic       s_axis_tvalid;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tuser;
  logic       m_axis_tvalid;
  logic [7:0] m_axis_tdata;

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  s_axis_tuser,
    output m_axis_tvalid,
    output m_axis_tdata
  );

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output s_axis_tuser,
    input  m_axis_tvalid,
    input  m_axis_tdata
  );

endinterface

// File: rtl/char_compare.sv
// Per-position hit: disabled positions always hit, else masked equality.
// Ports: char_i, pat_i, mask_i (8b), en_i -> hit_o.
module char_compare (
  input  logic [7:0] char_i,
  input  logic [7:0] pat_i,
  input  logic [7:0] mask_i,
  input  logic       en_i,
  output logic       hit_o
);

  assign hit_o = ~en_i | (((char_i ^ pat_i) & mask_i) == 8'h00);

endmodule

// File: rtl/word_matcher.sv
// Splits a char stream into words and emits the index of matching words.
// Ports: aclk/aresetn, pattern config (live), axis stream bundle.
module word_matcher
  import matcher_pkg::*;
#(
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] DELIM   = 8'h20
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [7:0]    word_size,
  input  logic [7:0]    result_mask,
  input  logic [63:0]   characters,
  input  logic [63:0]   masks,
  word_matcher_if.slave axis
);

  state_e     state_q;
  logic [3:0] pos_q;
  logic       ok_q;
  logic [7:0] idx_q;
  logic       mvalid_q;
  logic [7:0] mdata_q;

  logic [2:0] sel;
  logic       hit;
  logic       is_delim;
  logic       term;
  logic       chr;
  logic       full;
  logic       size_ok;
  logic       match;

  // Position 0 is evaluated on the beat that opens the word.
  assign sel = (state_q == ST_IDLE) ? 3'd0 : pos_q[2:0];

  char_compare u_cmp (
    .char_i (axis.s_axis_tdata),
    .pat_i  (characters[{sel, 3'b000} +: 8]),
    .mask_i (masks[{sel, 3'b000} +: 8]),
    .en_i   (result_mask[sel]),
    .hit_o  (hit)
  );

  assign is_delim = axis.s_axis_tdata == DELIM;
  assign term     = axis.s_axis_tvalid
                  & (axis.s_axis_tuser | is_delim);
  assign chr      = axis.s_axis_tvalid
                  & ~axis.s_axis_tuser & ~is_delim;

  // Word already as long as the pattern allows: further chars kill it.
  assign full     = ({4'd0, pos_q} >= word_size)
                  | (int'(pos_q) >= MAX_LEN);

  assign size_ok  = (word_size != 8'd0)
                  & (int'(word_size) <= MAX_LEN);

  assign match    = (state_q == ST_WORD) & ok_q & size_ok
                  & ({4'd0, pos_q} == word_size);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      pos_q    <= 4'd0;
      ok_q     <= 1'b1;
      idx_q    <= 8'd0;
      mvalid_q <= 1'b0;
      mdata_q  <= 8'd0;
    end else begin
      mvalid_q <= 1'b0;
      unique case (1'b1)
        term: begin
          if (state_q != ST_IDLE) begin
            mvalid_q <= match;
            if (match) mdata_q <= idx_q;
            idx_q <= idx_q + 8'd1;
          end
          // End of text restarts numbering for the next text.
          if (axis.s_axis_tuser) idx_q <= 8'd0;
          state_q <= ST_IDLE;
          pos_q   <= 4'd0;
          ok_q    <= 1'b1;
        end
        chr: begin
          case (state_q)
            ST_IDLE: begin
              state_q <= ST_WORD;
              ok_q    <= hit;
              pos_q   <= 4'd1;
            end
            ST_WORD: begin
              if (full) begin
                ok_q    <= 1'b0;
                state_q <= ST_SKIP;
              end else begin
                ok_q  <= ok_q & hit;
                pos_q <= pos_q + 4'd1;
              end
            end
            ST_SKIP: ;
            default: state_q <= ST_IDLE;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign axis.m_axis_tvalid = mvalid_q;
  assign axis.m_axis_tdata  = mdata_q;

endmodule

// File: tb/tb_word_matcher.sv
// Self-checking bench for word_matcher.
// Word-level reference model, directed scenarios plus random streams.
module tb_word_matcher;
  import matcher_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  word_size;
  logic [7:0]  result_mask;
  logic [63:0] characters;
  logic [63:0] masks;

  word_matcher_if bus();

  word_matcher dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .word_size   (word_size),
    .result_mask (result_mask),
    .characters  (characters),
    .masks       (masks),
    .axis        (bus)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int nres   = 0;
  int last_d = -1;

  byte unsigned cur[$];
  int           idx = 0;

  // Whole-word comparison against the pattern.
  function automatic bit ref_match();
    byte unsigned pc;
    byte unsigned mk;
    if (word_size == 8'd0 || word_size > 8'd8) return 1'b0;
    if (cur.size() != int'(word_size)) return 1'b0;
    for (int i = 0; i < cur.size(); i++) begin
      pc = characters[8*i +: 8];
      mk = masks[8*i +: 8];
      if (result_mask[i] && ((cur[i] ^ pc) & mk) != 0)
        return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic beat(input bit rn, input bit v,
                      input byte unsigned d, input bit u,
                      input string name);
    bit           ev = 1'b0;
    byte unsigned ed = 8'd0;
    if (!rn) begin
      cur.delete();
      idx = 0;
    end else if (v) begin
      if (u || d == DELIM) begin
        if (cur.size() > 0) begin
          ev  = ref_match();
          ed  = idx[7:0];
          idx = (idx + 1) % 256;
          cur.delete();
        end
        if (u) idx = 0;
      end else begin
        cur.push_back(d);
      end
    end
    aresetn           = rn;
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = d;
    bus.s_axis_tuser  = u;
    @(posedge aclk);
    #1;
    if (bus.m_axis_tvalid === 1'b1) begin
      nres++;
      last_d = int'(bus.m_axis_tdata);
    end
    checks++;
    if (bus.m_axis_tvalid !== ev) begin
      errors++;
      $display("FAIL %s tvalid: got %b want %b",
               name, bus.m_axis_tvalid, ev);
    end
    if (ev) begin
      checks++;
      if (bus.m_axis_tdata !== ed) begin
        errors++;
        $display("FAIL %s tdata: got %0d want %0d",
                 name, bus.m_axis_tdata, ed);
      end
    end
    aresetn           = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic send(input string s, input bit gaps,
                      input string name);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        beat(1, 0, 8'($urandom), 0, name);
      beat(1, 1, s[i], 0, name);
    end
  endtask

  task automatic end_text(input string name);
    beat(1, 1, CMD_END, 1, name);
  endtask

  task automatic set_cfg(input int ws, input string pat,
                         input logic [63:0] mk,
                         input logic [7:0] rm);
    characters = '0;
    for (int i = 0; i < pat.len(); i++)
      characters[8*i +: 8] = pat[i];
    word_size   = 8'(ws);
    masks       = mk;
    result_mask = rm;
  endtask

  task automatic expect_count(input int n0, input int want,
                              input string name);
    checks++;
    if (nres - n0 != want) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d",
               name, nres - n0, want);
    end
  endtask

  task automatic test_reset();
    beat(0, 0, 8'h00, 0, "reset");
    beat(0, 0, 8'h00, 0, "reset");
    checks++;
    if (bus.m_axis_tdata !== 8'd0) begin
      errors++;
      $display("FAIL reset tdata: got %0d want 0",
               bus.m_axis_tdata);
    end
  endtask

  task automatic test_basic();
    int n0 = nres;
    set_cfg(3, "cat", '1, 8'h07);
    send("a cat dog", 0, "basic");
    end_text("basic");
    expect_count(n0, 1, "basic");
    checks++;
    if (last_d != 1) begin
      errors++;
      $display("FAIL basic idx: got %0d want 1", last_d);
    end
  endtask

  task automatic test_case_insens();
    int n0 = nres;
    set_cfg(3, "cat", 64'hFFFF_FFFF_FFDF_DFDF, 8'h07);
    send("CAT cat cab", 0, "nocase");
    end_text("nocase");
    expect_count(n0, 2, "nocase");
  endtask

  task automatic test_wildcard();
    int n0 = nres;
    set_cfg(3, "cat", '1, 8'h05);
    send("cut cat ca", 0, "wild");
    end_text("wild");
    expect_count(n0, 2, "wild");
  endtask

  task automatic test_long_gaps();
    int n0 = nres;
    set_cfg(8, "abcdefgh", '1, 8'hFF);
    send("abcdefghi   abcdefgh", 1, "long");
    end_text("long");
    expect_count(n0, 1, "long");
    checks++;
    if (last_d != 1) begin
      errors++;
      $display("FAIL long idx: got %0d want 1", last_d);
    end
  endtask

  task automatic test_reset_mid();
    int n0 = nres;
    set_cfg(3, "cat", '1, 8'h07);
    send("dog ca", 0, "rstmid");
    beat(0, 1, "t", 0, "rstmid");
    send("cat", 0, "rstmid");
    beat(0, 1, DELIM, 0, "rstterm");
    send("cat", 0, "rstmid");
    end_text("rstmid");
    expect_count(n0, 1, "rstmid");
    checks++;
    if (last_d != 0) begin
      errors++;
      $display("FAIL rstmid idx: got %0d want 0", last_d);
    end
  endtask

  task automatic test_wrap();
    int n0;
    set_cfg(3, "cat", '1, 8'h07);
    for (int i = 0; i < 256; i++) send("x ", 0, "wrap");
    n0 = nres;
    send("cat ", 0, "wrap");
    end_text("wrap");
    expect_count(n0, 1, "wrap");
    checks++;
    if (last_d != 0) begin
      errors++;
      $display("FAIL wrap idx: got %0d want 0", last_d);
    end
  endtask

  task automatic test_illegal();
    int n0 = nres;
    set_cfg(0, "cat", '1, 8'h07);
    send("cat", 0, "size0");
    end_text("size0");
    set_cfg(9, "cat", '1, 8'h07);
    send("cat", 0, "size9");
    end_text("size9");
    expect_count(n0, 0, "illegal");
  endtask

  task automatic test_back_to_back();
    int n0 = nres;
    set_cfg(1, "a", '1, 8'h01);
    send("a a a a", 0, "b2b");
    end_text("b2b");
    expect_count(n0, 4, "b2b");
  endtask

  task automatic test_random();
    string        alpha = "abAB";
    string        pal   = "ab";
    logic [63:0]  mk;
    byte unsigned c;
    int           r;
    for (int k = 0; k < 25; k++) begin
      characters = '0;
      mk = '0;
      for (int i = 0; i < 8; i++) begin
        characters[8*i +: 8] = pal[$urandom_range(0, 1)];
        r = int'($urandom_range(0, 2));
        mk[8*i +: 8] = (r == 0) ? 8'hFF :
                       (r == 1) ? 8'hDF : 8'($urandom);
      end
      masks       = mk;
      word_size   = 8'($urandom_range(0, 4));
      result_mask = 8'($urandom);
      for (int j = 0; j < 80; j++) begin
        r = int'($urandom_range(0, 99));
        if (r < 10) begin
          beat(1, 0, 8'($urandom), 0, "rand");
        end else if (r < 40) begin
          beat(1, 1, DELIM, 0, "rand");
        end else if (r < 43) begin
          beat(0, r[0], DELIM, 0, "rand");
        end else if (r < 46) begin
          end_text("rand");
        end else begin
          c = alpha[$urandom_range(0, 3)];
          beat(1, 1, c, 0, "rand");
        end
      end
      end_text("rand");
    end
  endtask

  initial begin
    aresetn           = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tuser  = 1'b0;
    set_cfg(3, "cat", '1, 8'h07);
    #2;
    test_reset();
    test_basic();
    test_case_insens();
    test_wildcard();
    test_long_gaps();
    test_reset_mid();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
